// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART receiver, mid-bit sampling on an oversampling tick,
//               LSB-first, 1 start / NB_DATA data / 1 stop bit.
//               Define UART_RX_PARITY_EN to add a parity bit and o_parity_error.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int NB_DATA      = 8,
    parameter int OVERSAMPLING = 16,
    parameter int SB_TICK      = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_error,
`ifdef UART_RX_PARITY_EN
    output logic               o_parity_error,
`endif
    output logic               o_busy
);

    localparam int S_MAX = (OVERSAMPLING > SB_TICK) ? OVERSAMPLING : SB_TICK;
    localparam int S_W   = $clog2(S_MAX);
    localparam int N_W   = $clog2(NB_DATA);

    localparam logic [S_W-1:0] c_s_mid  = S_W'(OVERSAMPLING / 2 - 1);
    localparam logic [S_W-1:0] c_s_last = S_W'(OVERSAMPLING - 1);
    localparam logic [S_W-1:0] c_s_stop = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] c_n_last = N_W'(NB_DATA - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3
`ifdef UART_RX_PARITY_EN
        ,
        ST_PARITY = 3'd4
`endif
    } state_t;

    state_t             state_q, state_d;
    logic               rx_meta_q, rx_s_q;
    logic [S_W-1:0]     s_q, s_d;
    logic [N_W-1:0]     n_q, n_d;
    logic [NB_DATA-1:0] sr_q, sr_d;
    logic [NB_DATA-1:0] data_q, data_d;
    logic               done_q, done_d;
    logic               ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic               par_q, par_d;
    logic               perr_q, perr_d;
`endif

    // Line is asynchronous; both stages reset to the idle level.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        sr_d    = sr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif
        case (state_q)
            // The start edge is taken without waiting for a tick.
            ST_IDLE: begin
                if (!rx_s_q) begin
                    s_d     = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (i_tick) begin
                    if (s_q == c_s_mid) begin
                        if (!rx_s_q) begin
                            s_d     = '0;
                            n_d     = '0;
                            state_d = ST_DATA;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (i_tick) begin
                    if (s_q == c_s_last) begin
                        s_d  = '0;
                        sr_d = {rx_s_q, sr_q[NB_DATA-1:1]};
                        if (n_q == c_n_last) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            n_d = n_q + N_W'(1);
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (i_tick) begin
                    if (s_q == c_s_last) begin
                        s_d     = '0;
                        par_d   = rx_s_q;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
`endif
            ST_STOP: begin
                if (i_tick) begin
                    if (s_q == c_s_stop) begin
                        data_d  = sr_q;
                        ferr_d  = ~rx_s_q;
                        done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d  = (^sr_q) ^ par_q ^ PARITY_ODD;
`endif
                        state_d = ST_IDLE;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_data         = data_q;
    assign o_rx_done      = done_q;
    assign o_frame_error  = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign o_parity_error = perr_q;
`endif
    assign o_busy         = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed scoreboard bench for uart_rx (tick every 4 clocks,
//               16x oversampling, 64 clocks per bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       tick = 1'b0;
    logic       rx   = 1'b1;
    logic [7:0] data;
    logic       done;
    logic       ferr;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       perr;
    localparam int EXP_PULSES = 9;
    localparam int PAR_CLKS   = 64;
`else
    localparam int EXP_PULSES = 7;
    localparam int PAR_CLKS   = 0;
`endif

    uart_rx dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_tick        (tick),
        .i_rx          (rx),
        .o_data        (data),
        .o_rx_done     (done),
        .o_frame_error (ferr),
`ifdef UART_RX_PARITY_EN
        .o_parity_error(perr),
`endif
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            repeat (3) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    typedef struct packed {
        logic [7:0]  d;
        logic        fe;
        logic        pe;
        logic [31:0] t0;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   pulses = 0;
    logic done_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest frame sent.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t        e;
            int unsigned lat;
            pulses++;
            chk("no_consecutive_strobe", {31'd0, done_prev}, 32'd0);
            chk("strobe_expected", {31'd0, (sb.size() != 0)}, 32'd1);
            if (sb.size() != 0) begin
                e   = sb.pop_front();
                lat = cyc - e.t0;
                chk("rx_data", {24'd0, data}, {24'd0, e.d});
                chk("frame_error", {31'd0, ferr}, {31'd0, e.fe});
`ifdef UART_RX_PARITY_EN
                chk("parity_error", {31'd0, perr}, {31'd0, e.pe});
`endif
                checks++;
                assert (lat >= 600 + PAR_CLKS && lat <= 650 + PAR_CLKS)
                else begin
                    errors++;
                    $error("FAIL strobe_latency: observed=%0d clocks expected=%0d..%0d",
                           lat, 600 + PAR_CLKS, 650 + PAR_CLKS);
                end
            end
        end
        done_prev = done;
    end

    task automatic send_frame(input logic [7:0] d, input logic stop_v,
                              input int stop_clks, input logic pbit);
        @(negedge clk);
        rx = 1'b0;
        sb.push_back('{d: d, fe: ~stop_v, pe: (^d) ^ pbit, t0: cyc});
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (64) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = pbit;
        repeat (64) @(negedge clk);
`endif
        rx = stop_v;
        repeat (stop_clks) @(negedge clk);
        rx = 1'b1;
    endtask

    initial begin
        logic       busy_seen;
        logic [7:0] part;

        // Asynchronous reset asserted between clock edges.
        #3 rst = 1'b1;
        #1;
        chk("reset_data", {24'd0, data}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_ferr", {31'd0, ferr}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
`ifdef UART_RX_PARITY_EN
        chk("reset_perr", {31'd0, perr}, 32'd0);
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;

        busy_seen = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
        end
        chk("idle_busy", {31'd0, busy_seen}, 32'd0);

        send_frame(8'hA5, 1'b1, 64, ^8'hA5);
        repeat (100) @(negedge clk);
        chk("hold_a5", {24'd0, data}, 32'hA5);

        // Start glitch of three ticks
        @(negedge clk);
        rx = 1'b0;
        repeat (6) @(negedge clk);
        chk("glitch_busy", {31'd0, busy}, 32'd1);
        repeat (6) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        chk("glitch_idle", {31'd0, busy}, 32'd0);
        chk("glitch_data", {24'd0, data}, 32'hA5);

        // Stop bit low long enough to be sampled, then line restored
        send_frame(8'h3C, 1'b0, 40, ^8'h3C);
        repeat (200) @(negedge clk);
        chk("ferr_held", {31'd0, ferr}, 32'd1);
        send_frame(8'h55, 1'b1, 64, ^8'h55);
        repeat (100) @(negedge clk);
        chk("ferr_cleared", {31'd0, ferr}, 32'd0);

        send_frame(8'h00, 1'b1, 64, ^8'h00);
        send_frame(8'hFF, 1'b1, 64, ^8'hFF);
        send_frame(8'h81, 1'b1, 64, ^8'h81);
        repeat (100) @(negedge clk);
        chk("b2b_last", {24'd0, data}, 32'h81);

        // Frame 0x12 cut by reset during its 4th data bit
        part = 8'h12;
        @(negedge clk);
        rx = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = part[i];
            repeat ((i == 3) ? 30 : 64) @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        chk("midreset_data", {24'd0, data}, 32'd0);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_done", {31'd0, done}, 32'd0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (700) @(negedge clk);
        chk("midreset_no_strobe", {24'd0, data}, 32'd0);
        send_frame(8'h34, 1'b1, 64, ^8'h34);
        repeat (100) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 64, 1'b1);
        send_frame(8'h07, 1'b1, 64, 1'b0);
        repeat (100) @(negedge clk);
`endif

        repeat (100) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        chk("strobe_count", pulses, EXP_PULSES);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
